// File: rtl/io_uart_fifo_if.sv
// DMA/IO bus bundle for io_uart_fifo: write strobe/address/data, read
// strobe/address, upstream daisy-chain read data and the returned read data.
// master = bus side (drives strobes), slave = the UART block.
interface io_uart_fifo_if;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic        dma_io_radr_en;
  logic [13:0] dma_io_radr;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;

  modport master (
    output dma_io_we, dma_io_wadr, dma_io_wdata,
    output dma_io_radr_en, dma_io_radr, dma_io_rdata_in,
    input  dma_io_rdata
  );

  modport slave (
    input  dma_io_we, dma_io_wadr, dma_io_wdata,
    input  dma_io_radr_en, dma_io_radr, dma_io_rdata_in,
    output dma_io_rdata
  );
endinterface

// File: rtl/io_uart_fifo.sv
// UART I/O block: TX FIFO drained to the transmitter, RX FIFO filled from rout.
// Latency: bus read data one cycle after the strobe; TX char strobe one cycle after pop.
// Backpressure: TX drain stalls on uart_io_full; full FIFOs drop and set sticky flags.
//
// Ports: clk, rst (sync, active-high), bus (io_uart_fifo_if.slave: DMA/IO
// register bus), uart_io_char/uart_io_we/uart_io_full (transmitter),
// init_uart/uart_term (baud term), cpu_run_state/rout_en/rout (receiver),
// ext_uart_interrpt_1shot, rx_disable_echoback, uart_irq.
// Optional macro IO_UART_IRQ_EN enables the IEN register and uart_irq.
module io_uart_fifo #(
  parameter int          TX_DEPTH_LOG2 = 3,
  parameter int          RX_DEPTH_LOG2 = 3,
  parameter logic [13:0] BASE_ADR      = 14'h3F00
) (
  input  logic                 clk,
  input  logic                 rst,
  io_uart_fifo_if.slave        bus,
  output logic [7:0]           uart_io_char,
  output logic                 uart_io_we,
  input  logic                 uart_io_full,
  input  logic [1:0]           init_uart,
  output logic [15:0]          uart_term,
  input  logic                 cpu_run_state,
  input  logic                 rout_en,
  input  logic [7:0]           rout,
  output logic                 ext_uart_interrpt_1shot,
  output logic                 rx_disable_echoback,
  output logic                 uart_irq
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TXC_W    = TX_DEPTH_LOG2 + 1;
  localparam int RXC_W    = RX_DEPTH_LOG2 + 1;
  localparam logic [TXC_W-1:0] TX_FULL_CNT = TXC_W'(TX_DEPTH);
  localparam logic [RXC_W-1:0] RX_FULL_CNT = RXC_W'(RX_DEPTH);

  localparam logic [2:0] REG_OUTC = 3'd0;
  localparam logic [2:0] REG_STAT = 3'd1;
  localparam logic [2:0] REG_TERM = 3'd2;
  localparam logic [2:0] REG_RXCH = 3'd3;
  localparam logic [2:0] REG_RXEC = 3'd4;
  localparam logic [2:0] REG_IEN  = 3'd5;

  // Offsets are computed modulo 2**14 so a single compare covers the window.
  logic [13:0] wr_off, rd_off;
  logic        wr_hit;
  assign wr_off = bus.dma_io_wadr - BASE_ADR;
  assign rd_off = bus.dma_io_radr - BASE_ADR;
  assign wr_hit = bus.dma_io_we && (wr_off < 14'd6);

  logic wr_outc, wr_term, wr_rxec;
  assign wr_outc = wr_hit && (wr_off[2:0] == REG_OUTC);
  assign wr_term = wr_hit && (wr_off[2:0] == REG_TERM);
  assign wr_rxec = wr_hit && (wr_off[2:0] == REG_RXEC);

  // Registered read select; data is muxed from live state in the next cycle.
  logic       rd_vld;
  logic [2:0] rd_sel;
  logic       stat_rd, rxch_rd;
  assign stat_rd = rd_vld && (rd_sel == REG_STAT);
  assign rxch_rd = rd_vld && (rd_sel == REG_RXCH);

  logic [7:0] tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wp, tx_rp;
  logic [TXC_W-1:0]         tx_count;
  logic tx_full, tx_empty, tx_push, tx_pop;

  logic [7:0] rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wp, rx_rp;
  logic [RXC_W-1:0]         rx_count;
  logic rx_full, rx_empty, rx_push_req, rx_push, rx_pop;

  logic       tx_drop, rx_overrun, rxec;
  logic [7:0] outc_last;
  logic [15:0] term_init;

  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_empty = (tx_count == '0);
  // Gating on uart_io_we spaces strobes at least two cycles apart.
  assign tx_pop   = !tx_empty && !uart_io_full && !uart_io_we;
  assign tx_push  = wr_outc && (!tx_full || tx_pop);

  assign rx_full     = (rx_count == RX_FULL_CNT);
  assign rx_empty    = (rx_count == '0);
  assign rx_push_req = cpu_run_state && rout_en;
  assign rx_pop      = rxch_rd && !rx_empty;
  // A coincident RXCH pop frees a slot, so a push at full is still accepted.
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  assign ext_uart_interrpt_1shot = cpu_run_state & rout_en;
  assign rx_disable_echoback     = rxec & cpu_run_state;

  always_comb begin
    term_init = 16'd209;
    case (init_uart)
      2'd0: term_init = 16'd209;
      2'd1: term_init = 16'd261;
      2'd2: term_init = 16'd156;
      2'd3: term_init = 16'd184;
      default: term_init = 16'd209;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld       <= 1'b0;
      rd_sel       <= 3'd0;
      tx_wp        <= '0;
      tx_rp        <= '0;
      tx_count     <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      rx_count     <= '0;
      tx_drop      <= 1'b0;
      rx_overrun   <= 1'b0;
      rxec         <= 1'b0;
      outc_last    <= 8'd0;
      uart_io_we   <= 1'b0;
      uart_io_char <= 8'd0;
      uart_term    <= term_init;
    end else begin
      rd_vld <= bus.dma_io_radr_en && (rd_off < 14'd6);
      rd_sel <= rd_off[2:0];

      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;

      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;

      uart_io_we <= tx_pop;
      if (tx_pop) uart_io_char <= tx_mem[tx_rp];

      // A new drop/overrun event wins over a clearing read in the same cycle.
      if (wr_outc && !tx_push) tx_drop <= 1'b1;
      else if (stat_rd)        tx_drop <= 1'b0;
      if (rx_push_req && !rx_push)   rx_overrun <= 1'b1;
      else if (stat_rd || rxch_rd)   rx_overrun <= 1'b0;

      if (wr_outc) outc_last <= bus.dma_io_wdata[7:0];
      if (wr_term) uart_term <= bus.dma_io_wdata[15:0];
      if (wr_rxec) rxec      <= bus.dma_io_wdata[0];
    end
  end

  // Storage needs no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.dma_io_wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= rout;
  end

  logic [1:0] ien;
`ifdef IO_UART_IRQ_EN
  logic wr_ien;
  assign wr_ien = wr_hit && (wr_off[2:0] == REG_IEN);
  always_ff @(posedge clk) begin
    if (rst)         ien <= 2'b00;
    else if (wr_ien) ien <= bus.dma_io_wdata[1:0];
  end
  assign uart_irq = (ien[0] & ~rx_empty) | (ien[1] & tx_empty);
`else
  assign ien      = 2'b00;
  assign uart_irq = 1'b0;
`endif

  logic [7:0] rx_head;
  assign rx_head = rx_empty ? 8'd0 : rx_mem[rx_rp];

  always_comb begin
    bus.dma_io_rdata = bus.dma_io_rdata_in;
    if (rd_vld) begin
      case (rd_sel)
        REG_OUTC: bus.dma_io_rdata = {24'd0, outc_last};
        REG_STAT: bus.dma_io_rdata = {8'd0, 8'(rx_count), 8'(tx_count), 2'd0,
                                      tx_drop, rx_overrun, rx_full, rx_empty,
                                      tx_empty, tx_full};
        REG_TERM: bus.dma_io_rdata = {16'd0, uart_term};
        REG_RXCH: bus.dma_io_rdata = {22'd0, rx_overrun, !rx_empty, rx_head};
        REG_RXEC: bus.dma_io_rdata = {31'd0, rxec};
        REG_IEN:  bus.dma_io_rdata = {30'd0, ien};
        default:  bus.dma_io_rdata = bus.dma_io_rdata_in;
      endcase
    end
  end
endmodule

// File: tb/tb_io_uart_fifo.sv
module tb_io_uart_fifo;
  localparam logic [13:0] BASE   = 14'h3F00;
  localparam logic [13:0] A_OUTC = BASE;
  localparam logic [13:0] A_STAT = BASE + 14'd1;
  localparam logic [13:0] A_TERM = BASE + 14'd2;
  localparam logic [13:0] A_RXCH = BASE + 14'd3;
  localparam logic [13:0] A_RXEC = BASE + 14'd4;
  localparam logic [13:0] A_IEN  = BASE + 14'd5;
  localparam int TXD = 8;
  localparam int RXD = 8;
`ifdef IO_UART_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  uart_io_char;
  logic        uart_io_we;
  logic        uart_io_full;
  logic [1:0]  init_uart;
  logic [15:0] uart_term;
  logic        cpu_run_state, rout_en;
  logic [7:0]  rout;
  logic        ext_uart_interrpt_1shot, rx_disable_echoback, uart_irq;

  io_uart_fifo_if bus ();

  io_uart_fifo #(.TX_DEPTH_LOG2(3), .RX_DEPTH_LOG2(3), .BASE_ADR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .uart_io_char(uart_io_char), .uart_io_we(uart_io_we), .uart_io_full(uart_io_full),
    .init_uart(init_uart), .uart_term(uart_term),
    .cpu_run_state(cpu_run_state), .rout_en(rout_en), .rout(rout),
    .ext_uart_interrpt_1shot(ext_uart_interrpt_1shot),
    .rx_disable_echoback(rx_disable_echoback), .uart_irq(uart_irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int oneshots = 0;

  // Transmitter-side monitor: every strobe with its cycle stamp.
  logic [7:0] tx_got[$];
  int         tx_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && uart_io_we) begin
      tx_got.push_back(uart_io_char);
      tx_cyc.push_back(cyc);
    end
  end

  // Reference model: FIFO contents as queues plus the two sticky flags.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit m_drop = 1'b0;
  bit m_ovr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    bus.dma_io_we = 1'b1; bus.dma_io_wadr = a; bus.dma_io_wdata = d;
    tick();
    bus.dma_io_we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    bus.dma_io_radr_en = 1'b1; bus.dma_io_radr = a;
    tick();
    bus.dma_io_radr_en = 1'b0;
    d = bus.dma_io_rdata;
    tick();
  endtask

  function automatic logic [15:0] term_of(input int i);
    case (i)
      0: return 16'd209;
      1: return 16'd261;
      2: return 16'd156;
      default: return 16'd184;
    endcase
  endfunction

  function automatic logic [31:0] stat_of(input int rxc, input int txc, input bit drop, input bit ovr);
    return {8'd0, 8'(rxc), 8'(txc), 2'b00, drop, ovr,
            rxc == RXD, rxc == 0, txc == 0, txc == TXD};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tx_q.delete(); rx_q.delete();
    m_drop = 1'b0; m_ovr = 1'b0;
  endtask

  // CPU write to OUTC; only used while the transmitter is held full.
  task automatic m_tx_write(input logic [7:0] c);
    wr(A_OUTC, {24'd0, c});
    if (tx_q.size() < TXD) tx_q.push_back(c);
    else m_drop = 1'b1;
  endtask

  task automatic m_strobe(input logic [7:0] c);
    rout_en = 1'b1; rout = c;
    #1;
    if (ext_uart_interrpt_1shot) oneshots++;
    tick();
    rout_en = 1'b0;
    if (cpu_run_state) begin
      if (rx_q.size() < RXD) rx_q.push_back(c);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic m_rxch(input string tag);
    logic [31:0] e, d;
    e = {22'd0, m_ovr, rx_q.size() != 0, (rx_q.size() != 0) ? rx_q[0] : 8'h00};
    rd(A_RXCH, d);
    if (rx_q.size() != 0) void'(rx_q.pop_front());
    m_ovr = 1'b0;
    check(tag, d, e);
  endtask

  task automatic m_stat(input string tag, input int txc);
    logic [31:0] d;
    rd(A_STAT, d);
    check(tag, d, stat_of(rx_q.size(), txc, m_drop, m_ovr));
    m_drop = 1'b0; m_ovr = 1'b0;
  endtask

  logic [31:0] d;
  logic [31:0] up;
  int n, n0;
  int order[4] = '{0, 1, 3, 2};

  initial begin
    up = $urandom;
    bus.dma_io_we = 1'b0; bus.dma_io_wadr = '0; bus.dma_io_wdata = '0;
    bus.dma_io_radr_en = 1'b0; bus.dma_io_radr = '0; bus.dma_io_rdata_in = up;
    uart_io_full = 1'b0; init_uart = 2'd0;
    cpu_run_state = 1'b0; rout_en = 1'b0; rout = 8'd0;

    // Reset: baud term reloaded from init_uart on every reset, ending with 2.
    for (int i = 0; i < 4; i++) begin
      init_uart = 2'(order[i]);
      do_reset();
      check("term_reset", 32'(uart_term), 32'(term_of(order[i])));
    end
    check("we_reset", 32'(uart_io_we), 32'd0);
    check("char_reset", 32'(uart_io_char), 32'd0);
    check("rdata_passthru", bus.dma_io_rdata, up);
    check("irq_reset", 32'(uart_irq), 32'd0);
    rd(A_STAT, d); check("stat_reset", d, 32'h0000_0006);
    rd(A_OUTC, d); check("outc_reset", d, 32'd0);
    rd(A_RXEC, d); check("rxec_reset", d, 32'd0);
    rd(A_IEN, d);  check("ien_reset", d, 32'd0);
    wr(A_TERM, 32'h0000_1234);
    rd(A_TERM, d); check("term_rw", d, 32'h0000_1234);
    check("term_out", 32'(uart_term), 32'h0000_1234);

    // TX overfill while the transmitter is busy.
    uart_io_full = 1'b1;
    tx_got.delete(); tx_cyc.delete();
    for (int i = 0; i < 9; i++) m_tx_write(8'h41 + 8'(i));
    rd(A_STAT, d); check("stat_tx_full", d, 32'h0000_0825);
    m_drop = 1'b0;
    rd(A_STAT, d); check("stat_drop_clr", d, 32'h0000_0805);
    check("tx_held", 32'(tx_got.size()), 32'd0);
    uart_io_full = 1'b0;
    repeat (30) tick();
    check("tx_pulses", 32'(tx_got.size()), 32'd8);
    for (int i = 0; i < 8 && i < tx_got.size(); i++)
      check("tx_char", 32'(tx_got[i]), 32'(tx_q[i]));
    for (int i = 1; i < 8 && i < tx_cyc.size(); i++)
      check("tx_spacing", 32'(tx_cyc[i] - tx_cyc[i-1]), 32'd2);
    tx_q.delete();

    // Random TX burst drained under a random busy pattern.
    uart_io_full = 1'b1;
    tx_got.delete(); tx_cyc.delete();
    n = $urandom_range(3, 7);
    for (int i = 0; i < n; i++) m_tx_write(8'($urandom));
    rd(A_OUTC, d); check("outc_last", d, {24'd0, tx_q[n-1]});
    m_stat("stat_tx_rand", n);
    for (int i = 0; i < 60; i++) begin
      uart_io_full = 1'($urandom);
      tick();
    end
    uart_io_full = 1'b0;
    repeat (20) tick();
    check("tx_rand_cnt", 32'(tx_got.size()), 32'(n));
    for (int i = 0; i < n && i < tx_got.size(); i++)
      check("tx_rand_char", 32'(tx_got[i]), 32'(tx_q[i]));
    for (int i = 1; i < tx_cyc.size(); i++)
      check("tx_rand_gap", 32'(tx_cyc[i] - tx_cyc[i-1] >= 2), 32'd1);
    tx_q.delete();
    m_stat("stat_tx_drained", 0);

    // RX capture only while the CPU runs.
    cpu_run_state = 1'b1;
    oneshots = 0;
    m_strobe(8'h61); m_strobe(8'h62); m_strobe(8'h63);
    check("oneshot_cnt", 32'(oneshots), 32'd3);
    rd(A_RXCH, d); check("rxch_0x61", d, 32'h0000_0161); void'(rx_q.pop_front());
    m_rxch("rxch_b"); m_rxch("rxch_c"); m_rxch("rxch_empty");
    cpu_run_state = 1'b0;
    oneshots = 0;
    m_strobe(8'h70);
    check("oneshot_idle", 32'(oneshots), 32'd0);
    m_rxch("rxch_idle");

    // RX overrun, RXCH-read clear, and pop+push at full.
    cpu_run_state = 1'b1;
    for (int i = 0; i < 9; i++) m_strobe(8'($urandom));
    rd(A_RXCH, d); check("rxch_ovr_bit", 32'(d[9]), 32'd1);
    check("rxch_ovr_char", d, {22'd0, 1'b1, 1'b1, rx_q[0]});
    void'(rx_q.pop_front()); m_ovr = 1'b0;
    m_rxch("rxch_ovr_clr");
    m_strobe(8'($urandom)); m_strobe(8'($urandom));
    m_stat("stat_rx_full", 0);
    rout = 8'($urandom);
    bus.dma_io_radr_en = 1'b1; bus.dma_io_radr = A_RXCH;
    tick();
    bus.dma_io_radr_en = 1'b0;
    rout_en = 1'b1;
    d = bus.dma_io_rdata;
    tick();
    rout_en = 1'b0;
    check("rxch_coinc", d, {22'd0, 1'b0, 1'b1, rx_q[0]});
    void'(rx_q.pop_front());
    rx_q.push_back(rout);
    rd(A_STAT, d); check("stat_coinc", d, 32'h0008_000A);
    for (int i = 0; i < 9; i++) m_rxch("rxch_drain");

    // STAT read clears overrun.
    for (int i = 0; i < 9; i++) m_strobe(8'($urandom));
    rd(A_STAT, d); check("stat_ovr_set", 32'(d[4]), 32'd1);
    m_ovr = 1'b0;
    m_stat("stat_ovr_clr", 0);
    for (int i = 0; i < 8; i++) m_rxch("rxch_drain2");

    // Echo-back disable.
    wr(A_RXEC, 32'd1);
    rd(A_RXEC, d); check("rxec_rw", d, 32'd1);
    check("echo_run", 32'(rx_disable_echoback), 32'd1);
    cpu_run_state = 1'b0; #1;
    check("echo_idle", 32'(rx_disable_echoback), 32'd0);
    cpu_run_state = 1'b1;

    // Interrupt enables.
    wr(A_IEN, 32'd1);
    rd(A_IEN, d); check("ien_rw1", d, IRQ_ON ? 32'd1 : 32'd0);
    check("irq_rx_empty", 32'(uart_irq), 32'd0);
    m_strobe(8'h5A);
    check("irq_rx", 32'(uart_irq), 32'(IRQ_ON));
    m_rxch("rxch_irq");
    check("irq_rx_drained", 32'(uart_irq), 32'd0);
    wr(A_IEN, 32'd2);
    check("irq_tx_empty", 32'(uart_irq), 32'(IRQ_ON));
    rd(A_IEN, d); check("ien_rw2", d, IRQ_ON ? 32'd2 : 32'd0);
    wr(A_IEN, 32'd0);

    // Unmapped addresses pass the daisy chain through.
    rd(BASE + 14'd6, d); check("unmapped_hi", d, up);
    rd(BASE - 14'd1, d); check("unmapped_lo", d, up);

    // Reset while draining: contents discarded, no further strobes.
    uart_io_full = 1'b1;
    for (int i = 0; i < 5; i++) m_tx_write(8'($urandom));
    m_strobe(8'h11); m_strobe(8'h22);
    uart_io_full = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("we_in_reset", 32'(uart_io_we), 32'd0);
    n0 = tx_got.size();
    tick();
    rst = 1'b0;
    tx_q.delete(); rx_q.delete(); m_drop = 1'b0; m_ovr = 1'b0;
    repeat (10) tick();
    check("no_strobe_after_rst", 32'(tx_got.size()), 32'(n0));
    rd(A_STAT, d); check("stat_after_rst", d, 32'h0000_0006);
    check("term_after_rst", 32'(uart_term), 32'd156);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
